// File: rtl/microcode_sequencer_if.sv
// microcode_sequencer_if: opcode/flag inputs and control/status outputs between the sequencer and the datapath.
// The datapath side uses master; the sequencer uses slave.
interface microcode_sequencer_if;
    logic [3:0]  instruction;
    logic        ovf;
    logic        zf;
    logic [15:0] ctrl_data;
    logic [2:0]  step;
    logic        flag_c;
    logic        flag_z;
    logic        halted;
    modport master (output instruction, ovf, zf, input ctrl_data, step, flag_c, flag_z, halted);
    modport slave (input instruction, ovf, zf, output ctrl_data, step, flag_c, flag_z, halted);
endinterface

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: microstep counter, control word decode, flags register and sticky halt.
// Optional STEP_SKIP_EN returns to T0 early when the next microstep would be a NOP.
module microcode_sequencer #(
    parameter int NUM_STEPS = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    microcode_sequencer_if.slave bus
);
    localparam logic [2:0] LAST = 3'(NUM_STEPS - 1);
    typedef enum logic {RUN, HALT} state_t;
    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic        c_q, c_d, z_q, z_d;
    logic [15:0] cw;
    logic        wrap;

    function automatic logic [15:0] ucode(input logic [2:0] s, input logic [3:0] op, input logic c, input logic z);
        logic [15:0] w;
        w = 16'h0000;
        case (s)
            3'd0: w = 16'h4004;
            3'd1: w = 16'h1808;
            3'd2: case (op)
                4'b0001, 4'b0010, 4'b0011, 4'b0100: w = 16'h4400;
                4'b0101: w = 16'h0600;
                4'b0110: w = 16'h0402;
                4'b0111: w = c ? 16'h0402 : 16'h0000;
                4'b1000: w = z ? 16'h0402 : 16'h0000;
                4'b1110: w = 16'h0110;
                4'b1111: w = 16'h8000;
                default: w = 16'h0000;
            endcase
            3'd3: case (op)
                4'b0001: w = 16'h1200;
                4'b0010, 4'b0011: w = 16'h1020;
                4'b0100: w = 16'h2100;
                default: w = 16'h0000;
            endcase
            3'd4: case (op)
                4'b0010: w = 16'h0241;
                4'b0011: w = 16'h02C1;
                default: w = 16'h0000;
            endcase
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    always_comb begin
        cw = (state_q == HALT) ? 16'h8000 : ucode(step_q, bus.instruction, c_q, z_q);
`ifdef STEP_SKIP_EN
        wrap = (step_q == LAST) || (step_q >= 3'd2 && ucode(step_q + 3'd1, bus.instruction, c_q, z_q) == 16'h0000);
`else
        wrap = (step_q == LAST);
`endif
        step_d = (state_q == HALT) ? step_q : wrap ? 3'd0 : step_q + 3'd1;
        c_d = cw[0] ? bus.ovf : c_q;
        z_d = cw[0] ? bus.zf : z_q;
        state_d = (state_q == HALT || cw[15]) ? HALT : RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            step_q  <= 3'd0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    assign bus.ctrl_data = cw;
    assign bus.step      = step_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_z    = z_q;
    assign bus.halted    = (state_q == HALT);
endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer: table-driven per-cycle vectors plus directed halt, LDI-length and reset-abort sequences.
module tb_microcode_sequencer;
    localparam int NUM = 5;
`ifdef STEP_SKIP_EN
    localparam logic [2:0] HSTEP = 3'd0;
    localparam int LN = 4;
    logic [2:0] ldi_exp [LN] = '{3'd0, 3'd1, 3'd2, 3'd0};
`else
    localparam logic [2:0] HSTEP = 3'd3;
    localparam int LN = 6;
    logic [2:0] ldi_exp [LN] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;

    microcode_sequencer_if bus();
    microcode_sequencer #(.NUM_STEPS(NUM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic        sync;
        logic        chk;
        logic        rst_n;
        logic [3:0]  op;
        logic        ovf;
        logic        zf;
        logic [2:0]  st;
        logic [15:0] cw;
        logic        c;
        logic        z;
        logic        h;
    } vec_t;
    vec_t vq[$];

    task automatic v(input logic s, input logic [3:0] op, input logic ov, input logic zf,
                     input logic [2:0] st, input logic [15:0] cw, input logic c, input logic z);
        vq.push_back('{s, 1'b1, 1'b1, op, ov, zf, st, cw, c, z, 1'b0});
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ldi_cw(input logic [2:0] s);
        return s == 3'd0 ? 16'h4004 : s == 3'd1 ? 16'h1808 : s == 3'd2 ? 16'h0600 : 16'h0000;
    endfunction

    task automatic sync_t0();
        int n = 0;
        while (bus.step !== 3'd0 && n < NUM) begin
            chk("tail_nop", bus.ctrl_data, 16'h0000);
            @(negedge clk);
            #1;
            n++;
        end
        chk("sync_t0", {13'd0, bus.step}, 16'd0);
    endtask

    initial begin
        bus.instruction = 4'h0;
        bus.ovf = 1'b0;
        bus.zf = 1'b0;
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0});
        v(0, 4'h2, 1, 0, 3'd0, 16'h4004, 0, 0);
        v(0, 4'h2, 1, 0, 3'd1, 16'h1808, 0, 0);
        v(0, 4'h2, 1, 0, 3'd2, 16'h4400, 0, 0);
        v(0, 4'h2, 1, 0, 3'd3, 16'h1020, 0, 0);
        v(0, 4'h2, 1, 0, 3'd4, 16'h0241, 0, 0);
        v(0, 4'h7, 0, 1, 3'd0, 16'h4004, 1, 0);
        v(0, 4'h7, 0, 1, 3'd1, 16'h1808, 1, 0);
        v(0, 4'h7, 0, 1, 3'd2, 16'h0402, 1, 0);
        v(1, 4'h8, 0, 1, 3'd0, 16'h4004, 1, 0);
        v(0, 4'h8, 0, 1, 3'd1, 16'h1808, 1, 0);
        v(0, 4'h8, 0, 1, 3'd2, 16'h0000, 1, 0);
        v(1, 4'h3, 0, 1, 3'd0, 16'h4004, 1, 0);
        v(0, 4'h3, 0, 1, 3'd1, 16'h1808, 1, 0);
        v(0, 4'h3, 0, 1, 3'd2, 16'h4400, 1, 0);
        v(0, 4'h3, 0, 1, 3'd3, 16'h1020, 1, 0);
        v(0, 4'h3, 0, 1, 3'd4, 16'h02C1, 1, 0);
        v(0, 4'h8, 1, 0, 3'd0, 16'h4004, 0, 1);
        v(0, 4'h8, 1, 0, 3'd1, 16'h1808, 0, 1);
        v(0, 4'h8, 1, 0, 3'd2, 16'h0402, 0, 1);
        v(1, 4'h7, 1, 0, 3'd0, 16'h4004, 0, 1);
        v(0, 4'h7, 1, 0, 3'd1, 16'h1808, 0, 1);
        v(0, 4'h7, 1, 0, 3'd2, 16'h0000, 0, 1);
        v(1, 4'h4, 0, 0, 3'd0, 16'h4004, 0, 1);
        v(0, 4'h4, 0, 0, 3'd1, 16'h1808, 0, 1);
        v(0, 4'h4, 0, 0, 3'd2, 16'h4400, 0, 1);
        v(0, 4'h4, 0, 0, 3'd3, 16'h2100, 0, 1);
        v(1, 4'hE, 0, 0, 3'd0, 16'h4004, 0, 1);
        v(0, 4'hE, 0, 0, 3'd1, 16'h1808, 0, 1);
        v(0, 4'hE, 0, 0, 3'd2, 16'h0110, 0, 1);
        v(1, 4'h6, 0, 0, 3'd0, 16'h4004, 0, 1);
        v(0, 4'h6, 0, 0, 3'd1, 16'h1808, 0, 1);
        v(0, 4'h6, 0, 0, 3'd2, 16'h0402, 0, 1);
        v(1, 4'h1, 0, 0, 3'd0, 16'h4004, 0, 1);
        v(0, 4'h1, 0, 0, 3'd1, 16'h1808, 0, 1);
        v(0, 4'h1, 0, 0, 3'd2, 16'h4400, 0, 1);
        v(0, 4'h1, 0, 0, 3'd3, 16'h1200, 0, 1);
        v(1, 4'h9, 0, 0, 3'd0, 16'h4004, 0, 1);
        v(0, 4'h9, 0, 0, 3'd1, 16'h1808, 0, 1);
        v(0, 4'h9, 0, 0, 3'd2, 16'h0000, 0, 1);
        v(1, 4'hF, 0, 0, 3'd0, 16'h4004, 0, 1);
        v(0, 4'hF, 0, 0, 3'd1, 16'h1808, 0, 1);
        v(0, 4'hF, 0, 0, 3'd2, 16'h8000, 0, 1);
        @(negedge clk);
        foreach (vq[i]) begin
            if (vq[i].sync) sync_t0();
            rst_n = vq[i].rst_n;
            bus.instruction = vq[i].op;
            bus.ovf = vq[i].ovf;
            bus.zf = vq[i].zf;
            #1;
            if (vq[i].chk) begin
                chk($sformatf("v%0d_step", i), {13'd0, bus.step}, {13'd0, vq[i].st});
                chk($sformatf("v%0d_ctrl", i), bus.ctrl_data, vq[i].cw);
                chk($sformatf("v%0d_flags", i), {13'd0, bus.flag_c, bus.flag_z, bus.halted}, {13'd0, vq[i].c, vq[i].z, vq[i].h});
            end
            @(negedge clk);
        end
        #1;
        chk("halt_set", {15'd0, bus.halted}, 16'd1);
        chk("halt_ctrl", bus.ctrl_data, 16'h8000);
        chk("halt_step", {13'd0, bus.step}, {13'd0, HSTEP});
        bus.ovf = 1'b1;
        bus.zf = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("halt_frozen_step", {13'd0, bus.step}, {13'd0, HSTEP});
        chk("halt_frozen_ctrl", bus.ctrl_data, 16'h8000);
        chk("halt_frozen_flags", {13'd0, bus.flag_c, bus.flag_z, bus.halted}, 16'b011);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("unhalt_step", {13'd0, bus.step}, 16'd0);
        chk("unhalt_ctrl", bus.ctrl_data, 16'h4004);
        chk("unhalt_flags", {13'd0, bus.flag_c, bus.flag_z, bus.halted}, 16'b000);
        bus.instruction = 4'h5;
        #1;
        for (int k = 0; k < LN; k++) begin
            chk($sformatf("ldi%0d_step", k), {13'd0, bus.step}, {13'd0, ldi_exp[k]});
            chk($sformatf("ldi%0d_ctrl", k), bus.ctrl_data, ldi_cw(ldi_exp[k]));
            if (k < LN - 1) begin
                @(negedge clk);
                #1;
            end
        end
        bus.instruction = 4'h2;
        bus.ovf = 1'b1;
        bus.zf = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_t3_step", {13'd0, bus.step}, 16'd3);
        chk("abort_t3_ctrl", bus.ctrl_data, 16'h1020);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_t3_after", {12'd0, bus.step, bus.flag_c}, 16'd0);
        chk("abort_t3_z", {15'd0, bus.flag_z}, 16'd0);
        repeat (4) @(negedge clk);
        #1;
        chk("abort_t4_ctrl", bus.ctrl_data, 16'h0241);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_t4_step", {13'd0, bus.step}, 16'd0);
        chk("abort_t4_flags", {14'd0, bus.flag_c, bus.flag_z}, 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by time %0t", $time);
        $fatal(1);
    end
endmodule
